// File: rtl/pipelined_processor_pkg.sv
// Shared definitions for the 16-bit 5-stage core: opcodes, instruction fields,
// pipeline register layouts and a decode helper.
package pipelined_processor_pkg;

  localparam int OPC_LSB = 11;
  localparam int RS_LSB  = 8;
  localparam int RD_LSB  = 5;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  ridx_t;

  typedef enum logic [4:0] {
    OP_NOP = 5'b00000,
    OP_NOT = 5'b00100,
    OP_ADD = 5'b11001,
    OP_LDD = 5'b01010,
    OP_STD = 5'b01100
  } opcode_e;

  typedef struct packed {
    opcode_e op;
    ridx_t   rd;
    word_t   a;     // R[rs]
    word_t   b;     // R[rd]
  } id_ex_t;

  typedef struct packed {
    opcode_e op;
    ridx_t   rd;
    word_t   res;
    word_t   addr;
    word_t   data;
  } ex_mem_t;

  typedef struct packed {
    logic  we;
    ridx_t rd;
    word_t data;
  } mem_wb_t;

  // Unknown opcodes collapse to NOP so later stages only see the five legal ops.
  function automatic opcode_e decode_op(input word_t ins);
    case (ins[OPC_LSB +: 5])
      OP_NOT:  decode_op = OP_NOT;
      OP_ADD:  decode_op = OP_ADD;
      OP_LDD:  decode_op = OP_LDD;
      OP_STD:  decode_op = OP_STD;
      default: decode_op = OP_NOP;
    endcase
  endfunction

  function automatic ridx_t rs_of(input word_t ins);
    rs_of = ins[RS_LSB +: 3];
  endfunction

  function automatic ridx_t rd_of(input word_t ins);
    rd_of = ins[RD_LSB +: 3];
  endfunction

endpackage

// File: rtl/pipelined_processor_regfile8x16.sv
// 8x16 register file: two write-through operand reads, one debug read,
// one synchronous write; reset loads R[n] = n.
module regfile8x16
  import pipelined_processor_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  ridx_t ra1,
  input  ridx_t ra2,
  input  ridx_t rdbg,
  output word_t rd1,
  output word_t rd2,
  output word_t rdbg_data,
  input  logic  we,
  input  ridx_t wa,
  input  word_t wd
);

  logic [7:0][15:0] regs;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[3'(i)] <= 16'(i);
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // WB data bypasses the array so decode sees a same-cycle write.
  assign rd1       = (we && wa == ra1) ? wd : regs[ra1];
  assign rd2       = (we && wa == ra2) ? wd : regs[ra2];
  assign rdbg_data = regs[rdbg];

endmodule

// File: rtl/pipelined_processor.sv
// 5-stage in-order 16-bit core with fill-loaded IMEM, DMEM and no hazard
// interlocks; software spaces dependent instructions.
module pipelined_processor
  import pipelined_processor_pkg::*;
#(
  parameter int IMEM_AW  = 10,
  parameter int DMEM_AW  = 8,
  parameter int RESET_PC = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  write_addr,
  output logic [15:0] result,
  input  logic        write_enable_fm,
  input  logic        rst_fm,
  input  logic [15:0] write_data_fm,
  input  logic [31:0] write_addr_fm,
  output logic [15:0] instruction
);

  word_t imem [2**IMEM_AW];
  word_t dmem [2**DMEM_AW];

  logic [IMEM_AW-1:0] pc;
  word_t              if_id;
  id_ex_t             id_ex;
  ex_mem_t            ex_mem;
  mem_wb_t            mem_wb;

  word_t              rs_val, rd_val, alu_res, load_data;
  logic [DMEM_AW-1:0] dm_addr;

  always_ff @(posedge clk) begin
    if (rst_fm) begin
      for (int i = 0; i < 2**IMEM_AW; i++) imem[IMEM_AW'(i)] <= '0;
    end else if (write_enable_fm) begin
      imem[write_addr_fm[IMEM_AW-1:0]] <= write_data_fm;
    end
  end

  regfile8x16 u_rf (
    .clk       (clk),
    .reset     (reset),
    .ra1       (rs_of(if_id)),
    .ra2       (rd_of(if_id)),
    .rdbg      (write_addr),
    .rd1       (rs_val),
    .rd2       (rd_val),
    .rdbg_data (result),
    .we        (mem_wb.we),
    .wa        (mem_wb.rd),
    .wd        (mem_wb.data)
  );

  always_comb begin
    alu_res   = (id_ex.op == OP_ADD) ? id_ex.a + id_ex.b : ~id_ex.b;
    dm_addr   = ex_mem.addr[DMEM_AW-1:0];
    load_data = dmem[dm_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= IMEM_AW'(RESET_PC);
      if_id  <= '0;
      id_ex  <= '{op: OP_NOP, rd: '0, a: '0, b: '0};
      ex_mem <= '{op: OP_NOP, rd: '0, res: '0, addr: '0, data: '0};
      mem_wb <= '{we: 1'b0, rd: '0, data: '0};
    end else begin
      pc     <= pc + IMEM_AW'(1);
      if_id  <= imem[pc];
      id_ex  <= '{op: decode_op(if_id), rd: rd_of(if_id), a: rs_val, b: rd_val};
      // LDD addresses through R[rs]; STD addresses through R[rd] and stores R[rs].
      ex_mem <= '{op: id_ex.op, rd: id_ex.rd, res: alu_res,
                  addr: (id_ex.op == OP_LDD) ? id_ex.a : id_ex.b, data: id_ex.a};
      mem_wb <= '{we:   ex_mem.op inside {OP_ADD, OP_NOT, OP_LDD},
                  rd:   ex_mem.rd,
                  data: (ex_mem.op == OP_LDD) ? load_data : ex_mem.res};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**DMEM_AW; i++) dmem[DMEM_AW'(i)] <= '0;
    end else if (ex_mem.op == OP_STD) begin
      dmem[dm_addr] <= ex_mem.data;
    end
  end

  assign instruction = if_id;

  logic unused_bits;
  assign unused_bits = ^{write_addr_fm[31:IMEM_AW], if_id[4:0], ex_mem.addr[15:DMEM_AW]};

endmodule

// File: tb/tb_pipelined_processor.sv
// Directed and random programs for pipelined_processor, checked against an
// instruction-level model with explicit register/memory visibility delays.
`timescale 1ns/1ps
module tb_pipelined_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  write_addr = '0;
  logic [15:0] result;
  logic        write_enable_fm = 1'b0;
  logic        rst_fm = 1'b0;
  logic [15:0] write_data_fm = '0;
  logic [31:0] write_addr_fm = '0;
  logic [15:0] instruction;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] prog [$];
  logic [15:0] exp_r [8];

  always #10 clk = ~clk;

  pipelined_processor dut (
    .clk             (clk),
    .reset           (reset),
    .write_addr      (write_addr),
    .result          (result),
    .write_enable_fm (write_enable_fm),
    .rst_fm          (rst_fm),
    .write_data_fm   (write_data_fm),
    .write_addr_fm   (write_addr_fm),
    .instruction     (instruction)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int r, input logic [15:0] exp);
    write_addr = 3'(r);
    #1;
    check($sformatf("%s_r%0d", tag, r), result, exp);
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 8; r++) check_reg(tag, r, exp_r[r]);
  endtask

  // Clear IMEM and fill prog from word 32 while the core is held in reset.
  task automatic load();
    reset  = 1'b1;
    rst_fm = 1'b1;
    tick();
    rst_fm = 1'b0;
    foreach (prog[i]) begin
      write_enable_fm = 1'b1;
      write_addr_fm   = 32 + i;
      write_data_fm   = prog[i];
      tick();
    end
    write_enable_fm = 1'b0;
  endtask

  task automatic start();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Instruction i reads registers after the result of instruction i-3 has
  // landed; data memory effects take place strictly in program order.
  task automatic model_run();
    logic [15:0] r [8];
    logic [15:0] dm [256];
    bit          wv [$];
    logic [2:0]  wr [$];
    logic [15:0] wd [$];
    for (int i = 0; i < 8; i++) r[i] = 16'(i);
    for (int i = 0; i < 256; i++) dm[i] = '0;
    for (int i = 0; i < prog.size() + 3; i++) begin
      if (i >= 3 && wv[i-3]) r[wr[i-3]] = wd[i-3];
      if (i < prog.size()) begin
        logic [15:0] ins, a, b, v;
        bit          we;
        ins = prog[i];
        a   = r[ins[10:8]];
        b   = r[ins[7:5]];
        we  = 1'b1;
        v   = '0;
        case (ins[15:11])
          5'b11001: v = a + b;
          5'b00100: v = ~b;
          5'b01010: v = dm[a[7:0]];
          5'b01100: begin dm[b[7:0]] = a; we = 1'b0; end
          default:  we = 1'b0;
        endcase
        wv.push_back(we);
        wr.push_back(ins[7:5]);
        wd.push_back(v);
      end
    end
    for (int i = 0; i < 8; i++) exp_r[i] = r[i];
  endtask

  function automatic logic [15:0] rand_ins();
    logic [4:0] op;
    case ($urandom_range(0, 5))
      0:       op = 5'b00000;
      1:       op = 5'b00100;
      2:       op = 5'b11001;
      3:       op = 5'b01010;
      4:       op = 5'b01100;
      default: op = 5'($urandom);
    endcase
    return {op, 3'($urandom), 3'($urandom), 5'($urandom)};
  endfunction

  initial begin
    // Reset only
    prog = {};
    load();
    start();
    check("rst_instr", instruction, 16'h0000);
    model_run();
    check_all("rst");

    // Store/load/add program from the fill port
    prog = {16'h615F, 16'h529F, 16'h0000, 16'h0000, 16'hCC3F};
    load();
    start();
    tick();
    check("fill_instr", instruction, 16'h615F);
    repeat (10) tick();
    model_run();
    check_all("fill");
    check_reg("fill_ldd", 4, 16'h0001);
    check_reg("fill_add", 1, 16'h0002);

    // ALU
    prog = {16'hC95F, 16'h207F};
    load();
    start();
    repeat (6) tick();
    check_reg("alu_add", 2, 16'h0003);
    check_reg("alu_not", 3, 16'hFFFC);
    check_reg("alu_src", 1, 16'h0001);

    // Back-to-back dependency reads the old value
    prog = {16'hC95F, 16'hCABF};
    load();
    start();
    repeat (8) tick();
    check_reg("haz_close", 5, 16'h0007);

    // Two NOPs of spacing reads the new value
    prog = {16'hC95F, 16'h0000, 16'h0000, 16'hCABF};
    load();
    start();
    repeat (10) tick();
    check_reg("haz_spaced", 5, 16'h0008);

    // rst_fm beats write_enable_fm on the same edge
    prog = {16'hC95F};
    load();
    rst_fm = 1'b1; write_enable_fm = 1'b1;
    write_addr_fm = 32; write_data_fm = 16'hC95F;
    tick();
    rst_fm = 1'b0; write_enable_fm = 1'b0;
    start();
    tick();
    check("prio_instr", instruction, 16'h0000);
    repeat (8) tick();
    check_reg("prio", 2, 16'h0002);

    // Undefined opcode has no effect
    prog = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    load();
    start();
    tick();
    check("undef_instr", instruction, 16'h7FFF);
    repeat (10) tick();
    model_run();
    check_all("undef");

    // Reset in the middle of the ALU program
    prog = {16'hC95F, 16'h207F};
    load();
    start();
    repeat (5) tick();
    check_reg("mid_pre_r2", 2, 16'h0003);
    check_reg("mid_pre_r3", 3, 16'h0003);
    reset = 1'b1;
    tick();
    check_reg("mid_r2", 2, 16'h0002);
    check_reg("mid_r3", 3, 16'h0003);
    check("mid_instr", instruction, 16'h0000);
    reset = 1'b0;
    tick();
    check("mid_restart", instruction, 16'hC95F);
    repeat (5) tick();
    check_reg("mid_post_r2", 2, 16'h0003);
    check_reg("mid_post_r3", 3, 16'hFFFC);

    // Random programs, hazards included
    for (int t = 0; t < 20; t++) begin
      int len;
      len = $urandom_range(4, 24);
      prog = {};
      for (int i = 0; i < len; i++) prog.push_back(rand_ins());
      load();
      start();
      repeat (len + 6) tick();
      model_run();
      check_all($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
